// File: rtl/fir_pkg.sv
// fir_pkg: FSM state encoding and default geometry shared by the FIR sequencer and datapath blocks.
package fir_pkg;
  typedef enum logic [1:0] {IDLE, MAC, DRAIN, DONE} state_t;
  localparam int N_TAPS_DEF = 8;
  localparam int ADDR_W_DEF = 3;
  localparam int MAC_LAT_DEF = 2;
endpackage

// File: rtl/fir_ring_addr.sv
// fir_ring_addr: circular write pointer and modulo-N_TAPS sample slot for a given tap.
module fir_ring_addr
  import fir_pkg::*;
#(
  parameter int N_TAPS = N_TAPS_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              advance,
  input  logic [ADDR_W-1:0] tap,
  output logic [ADDR_W-1:0] ram_address
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_TAPS - 1);
  localparam logic [ADDR_W-1:0] NT = ADDR_W'(N_TAPS);
  logic [ADDR_W-1:0] wr_ptr;
  always_ff @(posedge clock)
    if (reset) wr_ptr <= '0;
    else if (advance) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + ADDR_W'(1);
  always_comb ram_address = tap > wr_ptr ? wr_ptr + NT - tap : wr_ptr - tap;
endmodule

// File: rtl/fir_sequencer.sv
// fir_sequencer: sample-accept / tap-walk / MAC-drain sequencer for the FIR datapath.
// Define FIR_SEQ_OVERRUN_CNT_EN to add the saturating dropped-sample counter overrun_cnt.
module fir_sequencer
  import fir_pkg::*;
#(
  parameter int N_TAPS = N_TAPS_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int MAC_LAT = MAC_LAT_DEF
`ifdef FIR_SEQ_OVERRUN_CNT_EN
  , parameter int OVR_W = 8
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid_in,
  output logic              ready_in,
  output logic [ADDR_W-1:0] rom_address,
  output logic [ADDR_W-1:0] ram_address,
  output logic              we,
  output logic              en,
  output logic              mac_init,
  output logic              valid_out,
  output logic              busy
`ifdef FIR_SEQ_OVERRUN_CNT_EN
  , output logic [OVR_W-1:0] overrun_cnt
`endif
);
  localparam int DW = MAC_LAT > 1 ? $clog2(MAC_LAT) : 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_TAPS - 1);
  localparam logic [DW-1:0] DLAST = DW'(MAC_LAT - 1);
  state_t state, state_n;
  logic [ADDR_W-1:0] tap, tap_n, ram_n;
  logic [DW-1:0] drain, drain_n;
  logic accept;
  assign ready_in = state == IDLE || state == DONE;
  assign accept = valid_in && ready_in;
  fir_ring_addr #(.N_TAPS(N_TAPS), .ADDR_W(ADDR_W)) u_ring (
    .clock(clock),
    .reset(reset),
    .advance(state_n == DONE),
    .tap(tap_n),
    .ram_address(ram_n)
  );
  always_comb begin
    state_n = state;
    tap_n = tap;
    drain_n = drain;
    case (state)
      IDLE: begin
        state_n = accept ? MAC : IDLE;
        tap_n = '0;
      end
      MAC: begin
        state_n = tap == LAST ? (MAC_LAT == 0 ? DONE : DRAIN) : MAC;
        tap_n = tap == LAST ? tap : tap + ADDR_W'(1);
        drain_n = '0;
      end
      DRAIN: begin
        state_n = drain == DLAST ? DONE : DRAIN;
        drain_n = drain + DW'(1);
      end
      default: begin
        state_n = accept ? MAC : IDLE;
        tap_n = '0;
      end
    endcase
  end
  // Outputs are registered from next-state so tap k appears the cycle after its decision.
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      tap <= '0;
      drain <= '0;
      rom_address <= '0;
      ram_address <= '0;
      we <= 1'b0;
      en <= 1'b0;
      mac_init <= 1'b0;
      valid_out <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      tap <= tap_n;
      drain <= drain_n;
      en <= state_n == MAC;
      we <= state_n == MAC && tap_n == '0;
      mac_init <= state_n == MAC && tap_n == '0;
      valid_out <= state_n == DONE;
      busy <= state_n != IDLE;
      rom_address <= state_n == MAC ? tap_n : rom_address;
      ram_address <= state_n == MAC ? ram_n : ram_address;
    end
`ifdef FIR_SEQ_OVERRUN_CNT_EN
  always_ff @(posedge clock)
    if (reset) overrun_cnt <= '0;
    else if (valid_in && !ready_in && overrun_cnt != '1) overrun_cnt <= overrun_cnt + OVR_W'(1);
`endif
endmodule

// File: tb/tb_fir_sequencer.sv
// tb_fir_sequencer: scoreboard bench for fir_sequencer (8 taps/lat 2 and 5 taps/lat 0 instances).
module tb_fir_sequencer;
  logic clock = 1'b0, reset = 1'b1, valid_in = 1'b0, valid_in5 = 1'b0;
  logic rdy, we, en, mi, vo, busy, rdy5, we5, en5, mi5, vo5, busy5;
  logic [2:0] rom, ram, rom5, ram5;
`ifdef FIR_SEQ_OVERRUN_CNT_EN
  logic [7:0] ovr, ovr5;
`endif
  fir_sequencer #(.N_TAPS(8), .ADDR_W(3), .MAC_LAT(2)) u_dut (
    .clock(clock), .reset(reset), .valid_in(valid_in), .ready_in(rdy),
    .rom_address(rom), .ram_address(ram), .we(we), .en(en), .mac_init(mi),
    .valid_out(vo), .busy(busy)
`ifdef FIR_SEQ_OVERRUN_CNT_EN
    , .overrun_cnt(ovr)
`endif
  );
  fir_sequencer #(.N_TAPS(5), .ADDR_W(3), .MAC_LAT(0)) u_dut5 (
    .clock(clock), .reset(reset), .valid_in(valid_in5), .ready_in(rdy5),
    .rom_address(rom5), .ram_address(ram5), .we(we5), .en(en5), .mac_init(mi5),
    .valid_out(vo5), .busy(busy5)
`ifdef FIR_SEQ_OVERRUN_CNT_EN
    , .overrun_cnt(ovr5)
`endif
  );
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;
  typedef struct {int c; int rom; int ram; int init;} rec_t;
  rec_t q[$], q5[$];
  int vq[$], vq5[$];
  int checks = 0, passes = 0;
  int wr = 0, wr5 = 0, a = 0;
  int seq3[8] = '{3, 2, 1, 0, 7, 6, 5, 4};
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
  endtask
  task automatic at_pos;
    @(posedge clock);
    #1;
  endtask
  task automatic at_neg(int n);
    @(negedge clock);
    while (cyc < n) @(negedge clock);
  endtask
  task automatic push8(int t, int k, int slot);
    rec_t r;
    r.c = t + k;
    r.rom = k;
    r.ram = slot;
    r.init = k == 0 ? 1 : 0;
    q.push_back(r);
  endtask
  task automatic expect8(int t);
    for (int k = 0; k < 8; k++) push8(t, k, (wr - k + 8) % 8);
    vq.push_back(t + 10);
    wr = (wr + 1) % 8;
  endtask
  task automatic expect5(int t);
    rec_t r;
    for (int k = 0; k < 5; k++) begin
      r.c = t + k;
      r.rom = k;
      r.ram = (wr5 - k + 5) % 5;
      r.init = k == 0 ? 1 : 0;
      q5.push_back(r);
    end
    vq5.push_back(t + 5);
    wr5 = (wr5 + 1) % 5;
  endtask
  always @(negedge clock) begin
    rec_t r;
    if (en) begin
      if (q.size() == 0) chk("en_unexpected", 1, 0);
      else begin
        r = q.pop_front();
        chk("tap_cycle", cyc, r.c);
        chk("rom_address", int'(rom), r.rom);
        chk("ram_address", int'(ram), r.ram);
        chk("we", int'(we), r.init);
        chk("mac_init", int'(mi), r.init);
      end
    end else chk("strobes_idle", int'({we, mi}), 0);
    if (vo) begin
      if (vq.size() == 0) chk("valid_out_unexpected", 1, 0);
      else chk("valid_out_cycle", cyc, vq.pop_front());
    end
  end
  always @(negedge clock) begin
    rec_t r;
    if (en5) begin
      if (q5.size() == 0) chk("en5_unexpected", 1, 0);
      else begin
        r = q5.pop_front();
        chk("tap5_cycle", cyc, r.c);
        chk("rom5_address", int'(rom5), r.rom);
        chk("ram5_address", int'(ram5), r.ram);
        chk("we5", int'(we5), r.init);
        chk("mac_init5", int'(mi5), r.init);
      end
    end else chk("strobes5_idle", int'({we5, mi5}), 0);
    if (vo5) begin
      if (vq5.size() == 0) chk("valid_out5_unexpected", 1, 0);
      else chk("valid_out5_cycle", cyc, vq5.pop_front());
    end
  end
  initial begin
    at_pos;
    at_pos;
    @(negedge clock);
    chk("rst_rom", int'(rom), 0);
    chk("rst_ram", int'(ram), 0);
    chk("rst_en", int'(en), 0);
    chk("rst_valid_out", int'(vo), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready_in", int'(rdy), 1);
`ifdef FIR_SEQ_OVERRUN_CNT_EN
    chk("rst_overrun", int'(ovr), 0);
`endif
    at_pos;
    reset = 1'b0;
    // single sample: slots 0,7..1, valid_out 10 cycles after first tap
    at_pos;
    valid_in = 1'b1;
    a = cyc + 1;
    expect8(a);
    at_pos;
    valid_in = 1'b0;
    at_neg(a + 8);
    chk("drain_rom_hold", int'(rom), 7);
    chk("drain_ram_hold", int'(ram), 1);
    chk("drain_ready_in", int'(rdy), 0);
    at_neg(a + 10);
    chk("done_busy", int'(busy), 1);
    at_neg(a + 11);
    chk("idle_busy", int'(busy), 0);
    chk("idle_ready_in", int'(rdy), 1);
    // valid_in held through MAC/DRAIN: extra requests dropped
    at_pos;
    valid_in = 1'b1;
    a = cyc + 1;
    expect8(a);
    repeat (11) at_pos;
    valid_in = 1'b0;
    at_neg(a + 11);
`ifdef FIR_SEQ_OVERRUN_CNT_EN
    chk("overrun_cnt", int'(ovr), 10);
`endif
    chk("held_busy", int'(busy), 0);
    // nine back-to-back samples, one every 11 cycles
    at_pos;
    valid_in = 1'b1;
    a = cyc + 1;
    for (int i = 0; i < 9; i++) expect8(a + 11 * i);
    repeat (89) at_pos;
    valid_in = 1'b0;
    at_neg(a + 99);
    // wr_ptr = 3 now
    at_pos;
    valid_in = 1'b1;
    a = cyc + 1;
    for (int k = 0; k < 8; k++) push8(a, k, seq3[k]);
    vq.push_back(a + 10);
    wr = (wr + 1) % 8;
    at_pos;
    valid_in = 1'b0;
    at_neg(a + 11);
    // reset at tap 4 aborts the sample
    at_pos;
    valid_in = 1'b1;
    a = cyc + 1;
    for (int k = 0; k < 5; k++) push8(a, k, (wr - k + 8) % 8);
    at_pos;
    valid_in = 1'b0;
    repeat (4) at_pos;
    reset = 1'b1;
    at_neg(a + 5);
    chk("abort_rom", int'(rom), 0);
    chk("abort_ram", int'(ram), 0);
    chk("abort_en", int'(en), 0);
    chk("abort_valid_out", int'(vo), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ready_in", int'(rdy), 1);
    at_pos;
    reset = 1'b0;
    wr = 0;
    wr5 = 0;
    repeat (15) at_pos;
    at_pos;
    valid_in = 1'b1;
    a = cyc + 1;
    expect8(a);
    at_pos;
    valid_in = 1'b0;
    at_neg(a + 11);
    // 5 taps, no MAC latency: six back-to-back samples, period 6
    at_pos;
    valid_in5 = 1'b1;
    a = cyc + 1;
    for (int i = 0; i < 6; i++) expect5(a + 6 * i);
    repeat (31) at_pos;
    valid_in5 = 1'b0;
    at_neg(a + 40);
    chk("q_left", q.size(), 0);
    chk("vq_left", vq.size(), 0);
    chk("q5_left", q5.size(), 0);
    chk("vq5_left", vq5.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
